// File: rtl/candy_alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared, registered ALU.
// Each accepted operation is issued to the ALU and held there. After a short
// execute phase the ALU result is returned to the consumer as a single
// response, and the arbiter then returns to idle.
module candy_alu_arbiter #(
    parameter int unsigned DataWidth = 24,
    parameter int unsigned OpWidth   = 8,
    parameter int unsigned MulLat    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [OpWidth-1:0]   req0_op,
    input  logic [DataWidth-1:0] req0_a,
    input  logic [DataWidth-1:0] req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [OpWidth-1:0]   req1_op,
    input  logic [DataWidth-1:0] req1_a,
    input  logic [DataWidth-1:0] req1_b,
    output logic [OpWidth-1:0]   alu_op_o,
    output logic [DataWidth-1:0] alu_reg1_o,
    output logic [DataWidth-1:0] alu_reg2_o,
    input  logic [DataWidth-1:0] alu_res_i,
    output logic                 rsp_valid_o,
    output logic                 rsp_id_o,
    output logic [DataWidth-1:0] rsp_data_o,
    input  logic                 rsp_ready_i,
    output logic                 busy_o
);

    // Opcode of the multi-cycle multiply; every other opcode takes one cycle.
    localparam logic [OpWidth-1:0] EXE_MUL = OpWidth'(3);
    localparam int unsigned CntWidth = (MulLat > 1) ? $clog2(MulLat + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic                 rr;
    logic [CntWidth-1:0]  cnt;
    logic                 grant;
    logic                 grant_id;
    logic [OpWidth-1:0]   sel_op;
    logic [DataWidth-1:0] sel_a;
    logic [DataWidth-1:0] sel_b;

    // Grant selection: rr breaks ties, a lone requester always wins.
    always_comb begin
        grant      = 1'b0;
        grant_id   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst && state == S_IDLE && (req0_valid || req1_valid)) begin
            grant    = 1'b1;
            grant_id = (req0_valid && req1_valid) ? rr : req1_valid;
        end
        req0_ready = grant && !grant_id;
        req1_ready = grant && grant_id;
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_op = grant_id ? req1_op : req0_op;
        sel_a  = grant_id ? req1_a  : req0_a;
        sel_b  = grant_id ? req1_b  : req0_b;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (grant) state_next = S_EXEC;
            S_EXEC:  if (cnt == '0) state_next = S_RESP;
            S_RESP:  if (rsp_ready_i) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Issue, execute countdown, result capture and response handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr          <= 1'b0;
            cnt         <= '0;
            alu_op_o    <= '0;
            alu_reg1_o  <= '0;
            alu_reg2_o  <= '0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= 1'b0;
            rsp_data_o  <= '0;
            busy_o      <= 1'b0;
        end else begin
            busy_o <= (state_next != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        alu_op_o   <= sel_op;
                        alu_reg1_o <= sel_a;
                        alu_reg2_o <= sel_b;
                        rsp_id_o   <= grant_id;
                        rr         <= ~grant_id;
                        cnt        <= (sel_op == EXE_MUL) ? CntWidth'(MulLat) : CntWidth'(1);
                    end
                end
                S_EXEC: begin
                    if (cnt == '0) begin
                        rsp_data_o  <= alu_res_i;
                        rsp_valid_o <= 1'b1;
                    end else begin
                        cnt <= cnt - CntWidth'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) rsp_valid_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_candy_alu_arbiter.sv
// Scoreboard bench for candy_alu_arbiter: a behavioural arbiter model predicts
// grants, ALU issue and responses; a monitor compares at every falling edge.
module tb_candy_alu_arbiter;

    localparam int DW = 24;
    localparam int OW = 8;
    localparam int MUL_LAT = 2;
    localparam logic [OW-1:0] OP_ADD = 8'h01;
    localparam logic [OW-1:0] OP_AND = 8'h02;
    localparam logic [OW-1:0] OP_MUL = 8'h03;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [OW-1:0] req0_op = '0, req1_op = '0;
    logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [OW-1:0] alu_op_o;
    logic [DW-1:0] alu_reg1_o, alu_reg2_o;
    logic [DW-1:0] alu_res = '0;
    logic          rsp_valid_o, rsp_id_o, busy_o;
    logic [DW-1:0] rsp_data_o;
    logic          rsp_ready_i = 1'b1;

    candy_alu_arbiter #(.DataWidth(DW), .OpWidth(OW), .MulLat(MUL_LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_op_o(alu_op_o), .alu_reg1_o(alu_reg1_o), .alu_reg2_o(alu_reg2_o),
        .alu_res_i(alu_res),
        .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o),
        .rsp_ready_i(rsp_ready_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Environment ALU: unknown opcodes return a ^ b.
    function automatic logic [DW-1:0] alu_fn(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        logic [DW-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_AND:  r = a & b;
            OP_MUL:  r = a * b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    always @(posedge clk) alu_res <= alu_fn(alu_op_o, alu_reg1_o, alu_reg2_o);

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t q[$];

    // Reference model state
    bit            m_free = 1'b1;
    bit            m_rr = 1'b0;
    bit            started = 1'b0;
    logic [OW-1:0] e_op = '0;
    logic [DW-1:0] e_a = '0, e_b = '0;
    bit            acc0 = 1'b0, acc1 = 1'b0;

    // Monitor: check outputs against the model, then advance the model.
    always @(negedge clk) begin
        int g;
        exp_t e;
        if (rst) begin
            q.delete();
            m_free = 1'b1; m_rr = 1'b0; started = 1'b0;
            e_op = '0; e_a = '0; e_b = '0;
            acc0 = 1'b0; acc1 = 1'b0;
        end else begin
            g = -1;
            if (m_free) begin
                if (req0_valid && req1_valid) g = int'(m_rr);
                else if (req0_valid) g = 0;
                else if (req1_valid) g = 1;
            end
            chk("req0_ready", 32'(req0_ready), 32'(g == 0));
            chk("req1_ready", 32'(req1_ready), 32'(g == 1));
            chk("busy", 32'(busy_o), 32'(!m_free));
            chk("alu_op", 32'(alu_op_o), 32'(e_op));
            chk("alu_reg1", 32'(alu_reg1_o), 32'(e_a));
            chk("alu_reg2", 32'(alu_reg2_o), 32'(e_b));
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            if (rsp_valid_o) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid_o), 32'(0));
                end else begin
                    chk("rsp_id", 32'(rsp_id_o), 32'(q[0].id));
                    chk("rsp_data", 32'(rsp_data_o), 32'(q[0].data));
                    if (!started) begin
                        chk("rsp_latency", 32'(cyc), 32'(q[0].due));
                        started = 1'b1;
                    end
                    if (rsp_ready_i) begin
                        void'(q.pop_front());
                        started = 1'b0;
                        m_free = 1'b1;
                    end
                end
            end else if (q.size() > 0 && !started && cyc > q[0].due) begin
                chk("rsp_late", 32'(rsp_valid_o), 32'(1));
                started = 1'b1;
            end
            if (g >= 0) begin
                e_op = (g == 1) ? req1_op : req0_op;
                e_a  = (g == 1) ? req1_a  : req0_a;
                e_b  = (g == 1) ? req1_b  : req0_b;
                e.id   = g;
                e.data = alu_fn(e_op, e_a, e_b);
                e.due  = cyc + ((e_op == OP_MUL) ? MUL_LAT : 1) + 2;
                q.push_back(e);
                m_rr   = (g == 0);
                m_free = 1'b0;
            end
        end
    end

    task automatic set_req(input int n, input logic [OW-1:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
        if (n == 0) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
        else        begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    endtask

    function automatic logic [OW-1:0] rand_op();
        case ($urandom % 4)
            0:       return OP_ADD;
            1:       return OP_AND;
            2:       return OP_MUL;
            default: return OW'($urandom);
        endcase
    endfunction

    // One cycle of stimulus. bp: 0 ready, 1 stalled, 2 random. gen: 0 none, 1 random, 2 refill.
    task automatic step(input int bp, input int gen);
        @(posedge clk); #1;
        if (acc0) req0_valid = 1'b0;
        if (acc1) req1_valid = 1'b0;
        for (int n = 0; n < 2; n++) begin
            if (((n == 0) ? !req0_valid : !req1_valid) &&
                (gen == 2 || (gen == 1 && $urandom % 3 == 0)))
                set_req(n, rand_op(), DW'($urandom), DW'($urandom));
        end
        rsp_ready_i = (bp == 0) ? 1'b1 : (bp == 1) ? 1'b0 : ($urandom % 4 != 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req0_ready"}, 32'(req0_ready), 32'(0));
        chk({tag, "_req1_ready"}, 32'(req1_ready), 32'(0));
        chk({tag, "_alu_op"}, 32'(alu_op_o), 32'(0));
        chk({tag, "_alu_reg1"}, 32'(alu_reg1_o), 32'(0));
        chk({tag, "_alu_reg2"}, 32'(alu_reg2_o), 32'(0));
        chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'(0));
        chk({tag, "_rsp_id"}, 32'(rsp_id_o), 32'(0));
        chk({tag, "_rsp_data"}, 32'(rsp_data_o), 32'(0));
        chk({tag, "_busy"}, 32'(busy_o), 32'(0));
    endtask

    initial begin
        // Reset state before any clock edge, with a requester already valid
        req0_valid = 1'b1;
        #2;
        chk_all_zero("reset");
        req0_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Single ADD
        set_req(0, OP_ADD, 24'd5, 24'd3);
        repeat (8) step(0, 0);

        // Contention straight after reset
        do_reset();
        set_req(0, OP_ADD, 24'd1, 24'd1);
        set_req(1, OP_AND, 24'hF0F0F0, 24'h0FF0FF);
        repeat (12) step(0, 0);

        // Multiply latency
        set_req(1, OP_MUL, 24'h000100, 24'h000010);
        repeat (8) step(0, 0);

        // Backpressure in RESP with a second requester waiting
        set_req(0, OP_ADD, DW'($urandom), DW'($urandom));
        set_req(1, rand_op(), DW'($urandom), DW'($urandom));
        rsp_ready_i = 1'b0;
        repeat (10) step(1, 0);
        repeat (15) step(0, 0);

        // Reset during EXEC
        req1_valid = 1'b0;
        set_req(0, OP_ADD, DW'($urandom), DW'($urandom));
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk_all_zero("midexec");
        @(posedge clk); #1;
        rst = 1'b0;
        set_req(0, rand_op(), DW'($urandom), DW'($urandom));
        set_req(1, rand_op(), DW'($urandom), DW'($urandom));
        repeat (14) step(0, 0);

        // Both requesters continuously valid
        repeat (30) step(0, 2);

        // Random traffic and backpressure
        repeat (800) step(2, 1);

        // Drain
        for (int i = 0; i < 200 && (q.size() != 0 || req0_valid || req1_valid); i++) step(0, 0);
        repeat (3) step(0, 0);
        chk("drain_queue_empty", 32'(q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
